output_streamer: RTL and testbench
==================================

# output_streamer

Reads the 4x4 matrix of 16-bit elements held in the CPU's output register and sends it to an external consumer one element at a time over a valid/ready handshake. It sits on the consumer side of the output register. It takes a snapshot of the register's 256-bit `data` bus when the CPU signals that a result is complete, then streams the 16 elements in row-major order, each tagged with its row and column.

## Interface
- `ELEM_W`, 16, width of one matrix element
- `DIM`, 4, matrix rows and columns; element count is DIM*DIM
- `clk`  input  1  system clock, rising edge
- `reset`  input  1  synchronous, active-high reset
- `load`  input  1  one-cycle pulse: `matrix_in` holds a complete new result
- `matrix_in`  input  ELEM_W*DIM*DIM (256)  output-register contents; element k is bits [16k+15:16k], k = row*4+col
- `out_ready`  input  1  consumer accepts `out_data` this cycle
- `out_valid`  output  1  `out_data`/`out_row`/`out_col`/`out_last` are valid
- `out_data`  output  ELEM_W  current element
- `out_row`  output  2  row of current element
- `out_col`  output  2  column of current element
- `out_last`  output  1  current element is k=15
- `busy`  output  1  a matrix is being streamed
- `done`  output  1  one-cycle pulse after the final element is accepted
- `load_dropped`  output  1  sticky: a `load` arrived while streaming and was ignored

## Operation
- The block has three states: IDLE, SEND and DONE.
- **IDLE:**
  - On `load`, capture `matrix_in` into the internal shadow register, set index k=0 and go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `out_valid`=1 and `busy`=1.
  - The outputs show shadow element k, with `out_row`=k[3:2] and `out_col`=k[1:0].
  - A transfer happens on a cycle where `out_valid` && `out_ready`.
  - A transfer with k<15 increments k.
  - A transfer with k=15 goes to DONE.
- **DONE:**
  - `done`=1 for exactly this one cycle; `out_valid`=0 and `busy`=0.
  - On `load`, capture and go to SEND with k=0; otherwise go to IDLE.
  - This lets matrices be streamed back to back with a one-cycle gap.
- Outputs do not depend combinationally on `out_ready`.
- While `out_valid`=1 and `out_ready`=0, all output fields hold stable.
- `load` in SEND, including the cycle of the final transfer:
  - The load is ignored and `load_dropped` is set to 1.
  - `load_dropped` stays 1 until reset.
  - The shadow register is not modified.
- Changes to `matrix_in` after capture have no effect on the stream in progress.
- Elements pass through unmodified; the block does no arithmetic.

## Timing
- **Reset values:** state=IDLE, k=0, shadow=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `busy`=0, `done`=0, `load_dropped`=0.
- **Latency:** `load` sampled at edge N gives `out_valid`=1 with element 0 from edge N onward (visible in cycle N+1).
- **Full-rate stream:** with `out_ready` held at 1, element k is presented in cycle N+1+k. `done` is asserted in cycle N+17.
- **Reset mid-stream:** the next edge forces all reset values. The partial matrix is abandoned, and no `done` is produced for it.
- **Reset together with `load`:** reset wins and the load is lost.

## Structure
- Shared package `matrix_pkg` holds:
  - `ELEM_W`=16, `DIM`=4, `MAT_W`=ELEM_W*DIM*DIM
  - the `stream_state_t` enum {IDLE, SEND, DONE}
  - the element-index width constant (4)
- The output register and any future matrix producer/consumer blocks use the same package.
- One combinational sub-module, `matrix_elem_sel`, maps (shadow, k) to the element. It is reused by other readers of the matrix memories.

## Test plan
- **Basic stream:**
  - Stimulus: load a matrix with element k = 16'h1000+k, `out_ready`=1.
  - Required response: 16 transfers, values 16'h1000..16'h100F; row/col go (0,0),(0,1)…(3,3); `out_last` is asserted only on 16'h100F; `done` pulses one cycle later.
- **Backpressure:**
  - Stimulus: toggle `out_ready` 1,0,0,1,… during the stream.
  - Required response: no element is skipped or duplicated, and the outputs stay stable during every stall cycle.
- **Ignored load:**
  - Stimulus: pulse `load` with a new matrix (all 16'hFFFF) at element 5 and again on the final-transfer cycle.
  - Required response: the stream continues with the original values, and `load_dropped`=1 until reset.
- **Back to back:**
  - Stimulus: pulse `load` in the DONE cycle.
  - Required response: the second matrix starts on the next cycle with element 0; 32 elements total, with exactly two `done` pulses.
- **Reset mid-stream:**
  - Stimulus: assert `reset` after element 7 is accepted.
  - Required response: all outputs at reset values on the next cycle and no `done`; a subsequent load streams from element 0.
- **Reset plus load:**
  - Stimulus: assert `reset` and `load` in the same cycle.
  - Required response: the block stays in IDLE with `out_valid`=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the 4x4 matrix datapath: element geometry,
// streamer state encoding and element-index helpers.
package matrix_pkg;

    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int N_ELEM = DIM * DIM;
    localparam int MAT_W  = ELEM_W * N_ELEM;
    localparam int IDX_W  = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } stream_state_t;

    // Row-major index: upper half of k is the row, lower half the column.
    function automatic logic [IDX_W/2-1:0] idx_row(input logic [IDX_W-1:0] k);
        return k[IDX_W-1:IDX_W/2];
    endfunction

    function automatic logic [IDX_W/2-1:0] idx_col(input logic [IDX_W-1:0] k);
        return k[IDX_W/2-1:0];
    endfunction

endpackage

// File: rtl/matrix_elem_sel.sv
// Picks element idx out of a flattened row-major matrix.
// Latency: combinational.
// Backpressure: none; pure lookup.
module matrix_elem_sel
    import matrix_pkg::*;
#(
    parameter int EW = ELEM_W,
    parameter int N  = N_ELEM,
    parameter int IW = IDX_W
) (
    input  logic [EW*N-1:0] mat,
    input  logic [IW-1:0]   idx,
    output logic [EW-1:0]   elem
);

    always_comb begin
        elem = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                elem = mat[i*EW +: EW];
            end
        end
    end

endmodule

// File: rtl/output_streamer.sv
// Snapshots the output-register matrix on load and streams its elements row-major.
// Latency: element 0 valid the cycle after load; one element per accepted handshake.
// Backpressure: out_ready low holds all output fields; loads during a stream are dropped.
module output_streamer #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [ELEM_W*DIM*DIM-1:0] matrix_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [ELEM_W-1:0]         out_data,
    output logic [1:0]                out_row,
    output logic [1:0]                out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      load_dropped
);

    import matrix_pkg::*;

    stream_state_t               state_q, state_d;
    logic [IDX_W-1:0]            k_q, k_d;
    logic [ELEM_W*DIM*DIM-1:0]   shadow_q, shadow_d;
    logic                        drop_q, drop_d;
    logic [ELEM_W-1:0]           elem;
    logic                        sending;

    matrix_elem_sel #(
        .EW (ELEM_W),
        .N  (DIM*DIM),
        .IW (IDX_W)
    ) u_sel (
        .mat  (shadow_q),
        .idx  (k_q),
        .elem (elem)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        drop_d   = drop_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shadow_d = matrix_in;
                    k_d      = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // Shadow stays frozen for the whole stream, final transfer included.
                if (load) begin
                    drop_d = 1'b1;
                end
                if (out_ready) begin
                    if (k_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (load) begin
                    shadow_d = matrix_in;
                    k_d      = '0;
                    state_d  = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            shadow_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            drop_q   <= drop_d;
        end
    end

    // Everything below decodes registered state only, so nothing depends on out_ready.
    always_comb begin
        sending      = (state_q == SEND);
        out_valid    = sending;
        busy         = sending;
        done         = (state_q == DONE);
        out_data     = sending ? elem : '0;
        out_row      = sending ? idx_row(k_q) : 2'd0;
        out_col      = sending ? idx_col(k_q) : 2'd0;
        out_last     = sending && (k_q == LAST_IDX);
        load_dropped = drop_q;
    end

endmodule

// File: tb/tb_output_streamer.sv
// Directed table-driven bench for output_streamer with hand-written multi-cycle sequences.
module tb_output_streamer;

    logic         clk;
    logic         reset;
    logic         load;
    logic [255:0] matrix_in;
    logic         out_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         load_dropped;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    output_streamer #(.ELEM_W(16), .DIM(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .matrix_in    (matrix_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .load_dropped (load_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    logic [23:0] got;
    assign got = {out_valid, out_data, out_row, out_col, out_last, busy, done};

    typedef struct {
        logic        rst;
        logic        ld;
        logic        rdy;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [15:0] mat_val(input int sel, input int k);
        case (sel)
            0:       return 16'(32'h1000 + k);
            1:       return 16'(32'h2000 + k * 273);
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [255:0] make_mat(input int sel);
        logic [255:0] m;
        for (int k = 0; k < 16; k++) m[16*k +: 16] = mat_val(sel, k);
        return m;
    endfunction

    function automatic logic [23:0] pack(input logic v, input logic [15:0] d, input logic [1:0] r,
                                         input logic [1:0] c, input logic l, input logic b,
                                         input logic dn);
        return {v, d, r, c, l, b, dn};
    endfunction

    function automatic logic [23:0] elem_exp(input int sel, input int k);
        logic [3:0] kk;
        kk = 4'(k);
        return pack(1'b1, mat_val(sel, k), kk[3:2], kk[1:0], kk == 4'd15, 1'b1, 1'b0);
    endfunction

    task automatic check(input string nm, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got={v,data,row,col,last,busy,done}=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int g, input int e);
        total++;
        if (g != e) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int sel);
        matrix_in = make_mat(sel);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Expects element 0 of matrix sel on the outputs; runs until DONE is visible.
    task automatic stream(input string nm, input int sel, input int pat, input bit ld,
                          output int n_xfer);
        int  k;
        bit  p5;
        bit  fin;
        k = 0; p5 = 0; fin = 0; n_xfer = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            check($sformatf("%s_k%0d", nm, k), elem_exp(sel, k));
            out_ready = (pat == 0) ? 1'b1 : (c % 3 == 0);
            if (ld && ((k == 5 && !p5) || (k == 15 && out_ready))) begin
                load = 1'b1;
                matrix_in = make_mat(2);
                if (k == 5) p5 = 1;
            end
            tick();
            load = 1'b0;
            if (out_ready) begin
                n_xfer++;
                if (k == 15) fin = 1;
                else k++;
            end
        end
        check_int({nm, "_finished"}, int'(fin), 1);
        check({nm, "_done"}, pack(1'b0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    endtask

    logic [23:0] idle_exp;
    int n, n2, d0;

    initial begin
        reset = 1'b1; load = 1'b0; out_ready = 1'b0;
        matrix_in = make_mat(0);
        idle_exp = pack(1'b0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Reset, reset+load, then a full-rate stream of matrix 0.
        tbl[0] = '{1'b1, 1'b0, 1'b0, idle_exp};
        tbl[1] = '{1'b1, 1'b1, 1'b1, idle_exp};
        tbl[2] = '{1'b0, 1'b0, 1'b1, idle_exp};
        tbl[3] = '{1'b0, 1'b1, 1'b1, elem_exp(0, 0)};
        for (int k = 1; k < 16; k++) tbl[3+k] = '{1'b0, 1'b0, 1'b1, elem_exp(0, k)};
        tbl[19] = '{1'b0, 1'b0, 1'b1, pack(1'b0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1)};
        tbl[20] = '{1'b0, 1'b0, 1'b1, idle_exp};

        for (int i = 0; i < 21; i++) begin
            reset = tbl[i].rst;
            load = tbl[i].ld;
            out_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp);
            if (i == 1) check_int("reset_dropped", int'(load_dropped), 0);
        end
        reset = 1'b0; load = 1'b0;
        check_int("basic_done_count", done_cnt, 1);
        check_int("basic_no_drop", int'(load_dropped), 0);

        // Backpressure 1,0,0,1,... with a matrix that changes after capture.
        do_load(1);
        matrix_in = make_mat(2);
        stream("bp", 1, 1, 0, n);
        check_int("bp_xfers", n, 16);
        tick();
        check("bp_idle", idle_exp);

        // Loads at element 5 and on the final transfer are ignored.
        do_load(0);
        stream("ign", 0, 0, 1, n);
        check_int("ign_dropped", int'(load_dropped), 1);
        tick();
        check("ign_no_restart", idle_exp);
        check_int("ign_dropped_sticky", int'(load_dropped), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check_int("ign_dropped_cleared", int'(load_dropped), 0);

        // Back to back: second load lands in the DONE cycle.
        d0 = done_cnt;
        do_load(0);
        stream("b2b_a", 0, 0, 0, n);
        do_load(1);
        stream("b2b_b", 1, 0, 0, n2);
        tick();
        check("b2b_idle", idle_exp);
        check_int("b2b_xfers", n + n2, 32);
        check_int("b2b_dones", done_cnt - d0, 2);
        check_int("b2b_no_drop", int'(load_dropped), 0);

        // Reset after element 7 is accepted.
        do_load(0);
        out_ready = 1'b1;
        repeat (8) tick();
        check("mid_elem8", elem_exp(0, 8));
        d0 = done_cnt;
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_reset", idle_exp);
        repeat (3) tick();
        check("mid_idle", idle_exp);
        check_int("mid_no_done", done_cnt - d0, 0);
        do_load(1);
        stream("mid_restart", 1, 0, 0, n);
        check_int("mid_restart_xfers", n, 16);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
